// File: rtl/scharr_window_ctrl_pkg.sv
// Shared types and defaults for the Scharr window controller slice.
package scharr_window_ctrl_pkg;

  // Controller FSM states, 2-bit encoded.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_RUN   = 2'd2,
    ST_FLUSH = 2'd3
  } state_t;

  localparam int DEF_IMG_W        = 640;
  localparam int DEF_IMG_H        = 480;
  localparam int DEF_SCHARR_SHIFT = 3;

  // Zero-extend a pixel into the signed width used by the gradient sums.
  function automatic logic signed [13:0] pix_ext(input logic [7:0] p);
    return $signed({6'd0, p});
  endfunction

endpackage

// File: rtl/scharr_3x3_gray.sv
// Combinational 3x3 Scharr gradient magnitude on an 8-bit gray window.
// Taps s0..s8 are row-major, top-left first; the centre tap has zero weight
// in both kernels, so it is not a port.
module scharr_3x3_gray
  import scharr_window_ctrl_pkg::*;
#(
  parameter int SCHARR_SHIFT = DEF_SCHARR_SHIFT
) (
  input  logic [7:0] s0,
  input  logic [7:0] s1,
  input  logic [7:0] s2,
  input  logic [7:0] s3,
  input  logic [7:0] s5,
  input  logic [7:0] s6,
  input  logic [7:0] s7,
  input  logic [7:0] s8,
  output logic [7:0] mag
);

  logic signed [13:0] gx;
  logic signed [13:0] gy;
  logic        [13:0] ax;
  logic        [13:0] ay;
  logic        [14:0] sum;
  logic        [14:0] shifted;

  // |gx| + |gy| with weights 3/10/3, shifted down and clamped to one byte.
  always_comb begin
    gx = 14'sd3  * (pix_ext(s2) - pix_ext(s0))
       + 14'sd10 * (pix_ext(s5) - pix_ext(s3))
       + 14'sd3  * (pix_ext(s8) - pix_ext(s6));
    gy = 14'sd3  * (pix_ext(s6) - pix_ext(s0))
       + 14'sd10 * (pix_ext(s7) - pix_ext(s1))
       + 14'sd3  * (pix_ext(s8) - pix_ext(s2));
    ax      = gx[13] ? $unsigned(-gx) : $unsigned(gx);
    ay      = gy[13] ? $unsigned(-gy) : $unsigned(gy);
    sum     = {1'b0, ax} + {1'b0, ay};
    shifted = sum >> SCHARR_SHIFT;
    mag     = (|shifted[14:8]) ? 8'hFF : shifted[7:0];
  end

endmodule

// File: rtl/scharr_line_buf.sv
// One line of pixel storage: asynchronous read of the old word at addr,
// synchronous write of the new word at the same addr.
module scharr_line_buf #(
  parameter int W  = 640,
  parameter int AW = $clog2(W)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [7:0]    wdata,
  output logic [7:0]    rdata
);

  logic [7:0] mem [W];

  // Read returns the word stored before this cycle's write (read-before-write).
  assign rdata = mem[addr];

  // Contents need no reset: every word is rewritten before it is consumed.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

endmodule

// File: rtl/scharr_window_ctrl.sv
// Streaming 3x3 Scharr controller: two line buffers, a 3-column window and a
// single registered output stage.
// Handshake: a beat transfers on a rising edge where valid & ready are both
// high; valid and its data hold until that edge, and ready never depends on
// valid in the same cycle.
module scharr_window_ctrl
  import scharr_window_ctrl_pkg::*;
#(
  parameter int IMG_W        = DEF_IMG_W,
  parameter int IMG_H        = DEF_IMG_H,
  parameter int SCHARR_SHIFT = DEF_SCHARR_SHIFT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       s_valid,
  output logic       s_ready,
  input  logic [7:0] s_data,
  input  logic       s_sof,
  output logic       m_valid,
  input  logic       m_ready,
  output logic [7:0] m_data,
  output logic       m_sof,
  output logic       m_eol,
  output logic       frame_done,
  output logic       busy,
  output logic       err_sync
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_TWO  = CW'(2);
  localparam logic [RW-1:0] ROW_TWO  = RW'(2);

  state_t        state;
  logic [CW-1:0] col;
  logic [RW-1:0] row;

  // Window columns, index 0 = oldest row (top), 2 = current row (bottom).
  logic [7:0] win_l [3];
  logic [7:0] win_m [3];
  logic [7:0] win_r [3];

  logic          accept;
  logic          restart;
  logic          take;
  logic [CW-1:0] cur_col;
  logic [RW-1:0] cur_row;
  logic          last_pix;
  logic          emit;
  logic [7:0]    lb0_rd;
  logic [7:0]    lb1_rd;
  logic [7:0]    kmag;

  assign s_ready    = (state != ST_FLUSH) && (!m_valid || m_ready);
  assign accept     = s_valid && s_ready;
  // An accepted s_sof always starts a frame at (0,0), also mid-frame.
  assign restart    = accept && s_sof;
  // Pixels accepted in IDLE without s_sof are dropped.
  assign take       = accept && (s_sof || (state != ST_IDLE));
  assign cur_col    = restart ? '0 : col;
  assign cur_row    = restart ? '0 : row;
  assign last_pix   = (cur_row == ROW_LAST) && (cur_col == COL_LAST);
  assign emit       = take && (cur_row >= ROW_TWO) && (cur_col >= COL_TWO);
  assign frame_done = (state == ST_FLUSH) && m_valid && m_ready;
  assign busy       = (state != ST_IDLE);

  // LB0 holds row-2, LB1 holds row-1; each accept ages the column by one row.
  scharr_line_buf #(.W(IMG_W), .AW(CW)) u_lb0 (
    .clk   (clk),
    .we    (take),
    .addr  (cur_col),
    .wdata (lb1_rd),
    .rdata (lb0_rd)
  );

  scharr_line_buf #(.W(IMG_W), .AW(CW)) u_lb1 (
    .clk   (clk),
    .we    (take),
    .addr  (cur_col),
    .wdata (s_data),
    .rdata (lb1_rd)
  );

  // Kernel sees the window as it will be after this accept's shift.
  scharr_3x3_gray #(.SCHARR_SHIFT(SCHARR_SHIFT)) u_kernel (
    .s0  (win_m[0]),
    .s1  (win_r[0]),
    .s2  (lb0_rd),
    .s3  (win_m[1]),
    .s5  (lb1_rd),
    .s6  (win_m[2]),
    .s7  (win_r[2]),
    .s8  (s_data),
    .mag (kmag)
  );

  // FSM, raster counters and sticky sync error.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      col      <= '0;
      row      <= '0;
      err_sync <= 1'b0;
    end else begin
      if (accept) begin
        if (s_sof)                  err_sync <= 1'b0;
        else if (state == ST_IDLE)  err_sync <= 1'b1;
      end
      if (take) begin
        if (last_pix) begin
          state <= ST_FLUSH;
          col   <= '0;
          row   <= '0;
        end else begin
          if (cur_col == COL_LAST) begin
            col <= '0;
            row <= cur_row + RW'(1);
          end else begin
            col <= cur_col + CW'(1);
            row <= cur_row;
          end
          if ((cur_row == ROW_TWO) && (cur_col == '0)) state <= ST_RUN;
          else if (restart)                            state <= ST_FILL;
        end
      end else if (frame_done) begin
        state <= ST_IDLE;
      end
    end
  end

  // Window shift: left <- mid <- right <- {LB0, LB1, new pixel}.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) begin
        win_l[i] <= '0;
        win_m[i] <= '0;
        win_r[i] <= '0;
      end
    end else if (take) begin
      win_l    <= win_m;
      win_m    <= win_r;
      win_r[0] <= lb0_rd;
      win_r[1] <= lb1_rd;
      win_r[2] <= s_data;
    end
  end

  // Output register: loads on an interior pixel, clears once consumed.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      m_data  <= '0;
      m_sof   <= 1'b0;
      m_eol   <= 1'b0;
    end else if (emit) begin
      m_valid <= 1'b1;
      m_data  <= kmag;
      m_sof   <= (cur_row == ROW_TWO) && (cur_col == COL_TWO);
      m_eol   <= (cur_col == COL_LAST);
    end else if (m_ready) begin
      m_valid <= 1'b0;
    end
  end

endmodule
